// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, default geometry and address-field helpers for
// the direct-mapped write-through data cache.
//   state_t            FSM state encoding
//   DEF_INDEX_WIDTH    default log2(lines)
//   DEF_OFFSET_WIDTH   default log2(words per line)
//   TAG_WIDTH          tag width at the default geometry
//   LINE_WORDS         words per line at the default geometry
//   addr_tag/addr_index/addr_offset  field extraction, right-justified in 32 bits
package dcache_pkg;

    localparam int unsigned DEF_INDEX_WIDTH  = 4;
    localparam int unsigned DEF_OFFSET_WIDTH = 2;
    localparam int unsigned TAG_WIDTH        = 30 - DEF_INDEX_WIDTH - DEF_OFFSET_WIDTH;
    localparam int unsigned LINE_WORDS       = 1 << DEF_OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL,
        WRITE,
        RESP
    } state_t;

    // Fields are returned right-justified; callers keep the low bits they need.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned iw,
                                             input int unsigned ow);
        return addr >> (iw + ow + 2);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned ow);
        return addr >> (ow + 2);
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: tag, valid and data arrays of the cache.
//   clk, rstn          clock; async active-low reset clears valid bits only
//   rd_index/rd_offset asynchronous read address
//   rd_tag/rd_valid/rd_word  read results
//   word_we, wr_index, wr_offset, wr_data  synchronous single-word write
//   tag_we, wr_tag     synchronous tag write + set valid (line wr_index)
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH,
    parameter int unsigned TAG_W        = 30 - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [INDEX_WIDTH-1:0]  rd_index,
    input  logic [OFFSET_WIDTH-1:0] rd_offset,
    output logic [TAG_W-1:0]        rd_tag,
    output logic                    rd_valid,
    output logic [31:0]             rd_word,
    input  logic                    word_we,
    input  logic [INDEX_WIDTH-1:0]  wr_index,
    input  logic [OFFSET_WIDTH-1:0] wr_offset,
    input  logic [31:0]             wr_data,
    input  logic                    tag_we,
    input  logic [TAG_W-1:0]        wr_tag
);

    localparam int unsigned LINES = 1 << INDEX_WIDTH;
    localparam int unsigned WORDS = 1 << OFFSET_WIDTH;

    logic [31:0]      data [LINES][WORDS];
    logic [TAG_W-1:0] tags [LINES];
    logic [LINES-1:0] valid;

    assign rd_tag   = tags[rd_index];
    assign rd_valid = valid[rd_index];
    assign rd_word  = data[rd_index][rd_offset];

    always_ff @(posedge clk) begin
        if (word_we) data[wr_index][wr_offset] <= wr_data;
        if (tag_we)  tags[wr_index] <= wr_tag;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       valid <= '0;
        else if (tag_we) valid[wr_index] <= 1'b1;
    end

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache.
//   clk, rstn                 clock, async active-low reset
//   req_valid/req_ready       CPU request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata request fields
//   resp_valid/resp_ready     response handshake
//   resp_rdata                load data (0 for stores)
//   mem_addr/mem_we/mem_wdata RAM port, driven only in REFILL and WRITE
//   mem_rdata                 RAM read data, combinational from mem_addr
//   hit_cnt/miss_cnt          load hit/miss counters, wrap
module dcache
    import dcache_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned TAG_W = 30 - INDEX_WIDTH - OFFSET_WIDTH;

    state_t                  state;
    logic                    lat_we;
    logic [31:0]             lat_addr;
    logic [31:0]             lat_wdata;
    logic [OFFSET_WIDTH-1:0] cnt;

    logic [31:0]             tag_full, idx_full, off_full;
    logic [TAG_W-1:0]        tag;
    logic [INDEX_WIDTH-1:0]  idx;
    logic [OFFSET_WIDTH-1:0] off;
    logic                    unused_addr_bits;

    logic [TAG_W-1:0]        rd_tag;
    logic                    rd_valid;
    logic [31:0]             rd_word;
    logic                    hit;
    logic                    word_we;
    logic [OFFSET_WIDTH-1:0] wr_offset;
    logic [31:0]             wr_data;
    logic                    tag_we;

    assign tag_full = addr_tag(lat_addr, INDEX_WIDTH, OFFSET_WIDTH);
    assign idx_full = addr_index(lat_addr, OFFSET_WIDTH);
    assign off_full = addr_offset(lat_addr);
    assign tag      = tag_full[TAG_W-1:0];
    assign idx      = idx_full[INDEX_WIDTH-1:0];
    assign off      = off_full[OFFSET_WIDTH-1:0];
    assign unused_addr_bits = ^{tag_full[31:TAG_W], idx_full[31:INDEX_WIDTH],
                                off_full[31:OFFSET_WIDTH], lat_addr[1:0]};

    assign hit = rd_valid && (rd_tag == tag);

    // Store hits patch the cached word in LOOKUP; refill writes each RAM word.
    always_comb begin
        word_we   = 1'b0;
        wr_offset = off;
        wr_data   = lat_wdata;
        tag_we    = 1'b0;
        if (state == LOOKUP && lat_we && hit) begin
            word_we = 1'b1;
        end else if (state == REFILL) begin
            word_we   = 1'b1;
            wr_offset = cnt;
            wr_data   = mem_rdata;
            tag_we    = (cnt == '1);
        end
    end

    dcache_line_store #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .OFFSET_WIDTH(OFFSET_WIDTH),
        .TAG_W       (TAG_W)
    ) u_store (
        .clk      (clk),
        .rstn     (rstn),
        .rd_index (idx),
        .rd_offset(off),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_word  (rd_word),
        .word_we  (word_we),
        .wr_index (idx),
        .wr_offset(wr_offset),
        .wr_data  (wr_data),
        .tag_we   (tag_we),
        .wr_tag   (tag)
    );

    // RAM port is combinational from state so the async-read RAM returns
    // the refill word within the same cycle.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state == REFILL) begin
            mem_addr = {lat_addr[31:OFFSET_WIDTH+2], cnt, 2'b00};
        end else if (state == WRITE) begin
            mem_addr  = {lat_addr[31:2], 2'b00};
            mem_we    = 1'b1;
            mem_wdata = lat_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lat_we) begin
                        state <= WRITE;
                    end else if (hit) begin
                        resp_rdata <= rd_word;
                        hit_cnt    <= hit_cnt + 32'd1;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        miss_cnt <= miss_cnt + 32'd1;
                        cnt      <= '0;
                        state    <= REFILL;
                    end
                end
                REFILL: begin
                    if (cnt == off) resp_rdata <= mem_rdata;
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    resp_rdata <= '0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed test of dcache against a behavioural async-read RAM.
module tb_dcache;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    dcache #(.INDEX_WIDTH(4), .OFFSET_WIDTH(2)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: 1024 words, contents loaded while ram_init is high.
    logic [31:0] ram [0:1023];
    logic        ram_init;
    logic        unused_tb_bits;
    assign mem_rdata      = ram[mem_addr[11:2]];
    assign unused_tb_bits = ^{mem_addr[31:12], mem_addr[1:0]};

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) begin
                if (i >= 4 && i <= 7)          ram[i] <= 32'hA0 + 32'(i - 4);
                else if (i >= 260 && i <= 263) ram[i] <= 32'hB0 + 32'(i - 260);
                else if (i >= 516 && i <= 519) ram[i] <= 32'hC0 + 32'(i - 516);
                else                           ram[i] <= 32'h5000_0000 | 32'(i);
            end
        end else if (mem_we) begin
            ram[mem_addr[11:2]] <= mem_wdata;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    logic [31:0] trace [$];
    int          we_cycles;
    logic [31:0] we_addr;
    logic [31:0] we_data;

    // Issue one request, measure latency from the accepting edge (counted as
    // edge 1), record RAM activity, optionally stall the response for 'hold'
    // cycles, then complete the handshake.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input int exp_lat, input int hold);
        int lat;
        trace.delete();
        we_cycles = 0;
        we_addr   = '0;
        we_data   = '0;
        check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        lat = 1;
        while (!resp_valid && lat < 40) begin
            if (mem_we) begin
                we_cycles++;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end else if (mem_addr != 0) begin
                trace.push_back(mem_addr);
            end
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_rdata"}, resp_rdata, exp_rdata);
        repeat (hold) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            check({name, "_hold_rdata"}, resp_rdata, exp_rdata);
            check({name, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check({name, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        rstn       = 1'b0;
        ram_init   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ram_init = 1'b0;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_hit", hit_cnt, 32'd0);
        check("rst_miss", miss_cnt, 32'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Cold miss refills line 1 word by word.
        do_req("ld10", 1'b0, 32'h10, 32'h0, 32'hA0, 6, 0);
        check("ld10_trace_n", 32'(trace.size()), 32'd4);
        if (trace.size() == 4) begin
            check("ld10_tr0", trace[0], 32'h10);
            check("ld10_tr1", trace[1], 32'h14);
            check("ld10_tr2", trace[2], 32'h18);
            check("ld10_tr3", trace[3], 32'h1C);
        end
        check("ld10_miss", miss_cnt, 32'd1);

        do_req("ld18", 1'b0, 32'h18, 32'h0, 32'hA2, 2, 0);
        check("ld18_trace_n", 32'(trace.size()), 32'd0);
        check("ld18_hit", hit_cnt, 32'd1);

        // Store hit: write-through plus cached word update.
        do_req("st14", 1'b1, 32'h14, 32'hDEADBEEF, 32'h0, 3, 0);
        check("st14_we_cycles", 32'(we_cycles), 32'd1);
        check("st14_we_addr", we_addr, 32'h14);
        check("st14_we_data", we_data, 32'hDEADBEEF);
        check("st14_ram", ram[5], 32'hDEADBEEF);
        check("st14_hit", hit_cnt, 32'd1);
        check("st14_miss", miss_cnt, 32'd1);
        do_req("ld14", 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 2, 0);
        check("ld14_hit", hit_cnt, 32'd2);

        // Store miss: RAM only, low address bits ignored.
        do_req("st400", 1'b1, 32'h403, 32'h12345678, 32'h0, 3, 0);
        check("st400_we_addr", we_addr, 32'h400);
        check("st400_ram", ram[256], 32'h12345678);
        do_req("ld400", 1'b0, 32'h400, 32'h0, 32'h12345678, 6, 0);
        check("ld400_miss", miss_cnt, 32'd2);

        // Conflict eviction on index 1, then reload from RAM.
        do_req("ld410", 1'b0, 32'h410, 32'h0, 32'hB0, 6, 0);
        check("ld410_miss", miss_cnt, 32'd3);
        do_req("ld14b", 1'b0, 32'h14, 32'h0, 32'hDEADBEEF, 6, 0);
        check("ld14b_miss", miss_cnt, 32'd4);

        // Response stall: outputs frozen for 5 cycles.
        do_req("hold18", 1'b0, 32'h18, 32'h0, 32'hA2, 2, 5);
        check("hold18_hit", hit_cnt, 32'd3);
        check("hold18_miss", miss_cnt, 32'd4);

        // Reset in the middle of a refill of 0x810 (index 1).
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h810;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_refill_addr", mem_addr, 32'h814);
        rstn = 1'b0;
        #1;
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_miss", miss_cnt, 32'd0);
        check("mid_rst_hit", hit_cnt, 32'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        do_req("ld810", 1'b0, 32'h810, 32'h0, 32'hC0, 6, 0);
        check("ld810_miss", miss_cnt, 32'd1);
        do_req("ld81c", 1'b0, 32'h81C, 32'h0, 32'hC3, 2, 0);
        check("ld81c_hit", hit_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
